// File: rtl/pwm_duty_ramp_if.sv
// Control/strobe inputs and duty outputs between the ramp sequencer and the PWM stage.
// slave = sequencer side, master = controller/PWM side.
interface pwm_duty_ramp_if #(
    parameter int DUTY_W = 16
);
    logic              en;
    logic              period_end;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic [2:0]        phase;
    logic              cycle_done;

    modport master (
        output en,
        output period_end,
        input  duty,
        input  duty_valid,
        input  phase,
        input  cycle_done
    );

    modport slave (
        input  en,
        input  period_end,
        output duty,
        output duty_valid,
        output phase,
        output cycle_done
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Breathing duty sequencer: ramps duty 0 -> DUTY_MAX -> 0, updating only on PWM period_end.
// Latency: duty/duty_valid register on the edge that samples period_end=1 (1 cycle).
// Backpressure: none; period_end is the only pacing and the consumer must accept every strobe.
module pwm_duty_ramp #(
    parameter int DUTY_W           = 16,
    parameter int DUTY_MAX         = 1000,
    parameter int STEP             = 10,
    parameter int PERIODS_PER_STEP = 4,
    parameter int HOLD_PERIODS     = 50
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    pwm_duty_ramp_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RAMP_UP   = 3'd1;
    localparam logic [2:0] HOLD_HIGH = 3'd2;
    localparam logic [2:0] RAMP_DOWN = 3'd3;
    localparam logic [2:0] HOLD_LOW  = 3'd4;

    localparam int CNT_MAX = (PERIODS_PER_STEP > HOLD_PERIODS) ? PERIODS_PER_STEP : HOLD_PERIODS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  PPS_LAST  = CNT_W'(PERIODS_PER_STEP - 1);
    // HOLD_PERIODS=0 behaves like 1: leave on the first strobe since pcnt enters at 0.
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'((HOLD_PERIODS == 0) ? 0 : HOLD_PERIODS - 1);
    localparam logic [DUTY_W-1:0] MAX_D     = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
    localparam logic [DUTY_W:0]   MAX_E     = (DUTY_W+1)'(DUTY_MAX);
    localparam logic [DUTY_W:0]   STEP_E    = (DUTY_W+1)'(STEP);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              duty_valid_q, duty_valid_d;
    logic              cycle_done_q, cycle_done_d;

    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] duty_up;
    logic [DUTY_W-1:0] duty_dn;

    // One extra bit so a near-full duty word cannot wrap before saturation.
    assign up_sum  = {1'b0, duty_q} + STEP_E;
    assign duty_up = (up_sum >= MAX_E) ? MAX_D : up_sum[DUTY_W-1:0];
    assign duty_dn = (duty_q <= STEP_D) ? '0 : duty_q - STEP_D;

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        duty_d       = duty_q;
        duty_valid_d = 1'b0;
        cycle_done_d = 1'b0;
        if (bus.period_end) begin
            if (!bus.en) begin
                if (state_q != IDLE) begin
                    state_d      = IDLE;
                    duty_d       = '0;
                    duty_valid_d = (duty_q != '0);
                    pcnt_d       = '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = RAMP_UP;
                        pcnt_d  = '0;
                    end
                    RAMP_UP: begin
                        if (pcnt_q == PPS_LAST) begin
                            pcnt_d       = '0;
                            duty_d       = duty_up;
                            duty_valid_d = 1'b1;
                            if (duty_up == MAX_D) state_d = HOLD_HIGH;
                        end else begin
                            pcnt_d = pcnt_q + CNT_W'(1);
                        end
                    end
                    HOLD_HIGH: begin
                        if (pcnt_q == HOLD_LAST) begin
                            pcnt_d  = '0;
                            state_d = RAMP_DOWN;
                        end else begin
                            pcnt_d = pcnt_q + CNT_W'(1);
                        end
                    end
                    RAMP_DOWN: begin
                        if (pcnt_q == PPS_LAST) begin
                            pcnt_d       = '0;
                            duty_d       = duty_dn;
                            duty_valid_d = 1'b1;
                            if (duty_dn == '0) state_d = HOLD_LOW;
                        end else begin
                            pcnt_d = pcnt_q + CNT_W'(1);
                        end
                    end
                    HOLD_LOW: begin
                        if (pcnt_q == HOLD_LAST) begin
                            pcnt_d       = '0;
                            state_d      = RAMP_UP;
                            cycle_done_d = 1'b1;
                        end else begin
                            pcnt_d = pcnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        duty_d  = '0;
                        pcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.duty_valid = duty_valid_q;
    assign bus.phase      = state_q;
    assign bus.cycle_done = cycle_done_q;
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench: strobe-by-strobe vector tables for two parameter sets plus reset/idle sequences.
module tb_pwm_duty_ramp;
    logic sys_clk = 1'b0;
    logic rst_n;

    always #5 sys_clk = ~sys_clk;

    pwm_duty_ramp_if #(.DUTY_W(16)) ia ();
    pwm_duty_ramp_if #(.DUTY_W(16)) ib ();

    pwm_duty_ramp #(
        .DUTY_W(16), .DUTY_MAX(100), .STEP(10), .PERIODS_PER_STEP(2), .HOLD_PERIODS(3)
    ) dut_a (
        .sys_clk(sys_clk), .rst_n(rst_n), .bus(ia.slave)
    );

    pwm_duty_ramp #(
        .DUTY_W(16), .DUTY_MAX(95), .STEP(10), .PERIODS_PER_STEP(1), .HOLD_PERIODS(0)
    ) dut_b (
        .sys_clk(sys_clk), .rst_n(rst_n), .bus(ib.slave)
    );

    typedef struct {
        logic        en;
        logic        pe;
        logic [15:0] duty;
        logic        vld;
        logic [2:0]  phase;
        logic        done;
    } vec_t;

    vec_t tv[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic en, input logic pe, input int d,
                                input logic vld, input int ph, input logic done);
        vec_t v;
        v.en    = en;
        v.pe    = pe;
        v.duty  = 16'(d);
        v.vld   = vld;
        v.phase = 3'(ph);
        v.done  = done;
        return v;
    endfunction

    task automatic add(input logic en, input logic pe, input int d,
                       input logic vld, input int ph, input logic done);
        tv.push_back(mk(en, pe, d, vld, ph, done));
    endtask

    task automatic check(input string name, input int which, input vec_t v);
        logic [15:0] ad;
        logic        av;
        logic [2:0]  ap;
        logic        ac;
        if (which == 0) begin
            ad = ia.duty; av = ia.duty_valid; ap = ia.phase; ac = ia.cycle_done;
        end else begin
            ad = ib.duty; av = ib.duty_valid; ap = ib.phase; ac = ib.cycle_done;
        end
        checks++;
        if (ad !== v.duty || av !== v.vld || ap !== v.phase || ac !== v.done) begin
            errors++;
            $display("FAIL %s: got duty=%0d vld=%b phase=%0d done=%b, want duty=%0d vld=%b phase=%0d done=%b",
                     name, ad, av, ap, ac, v.duty, v.vld, v.phase, v.done);
        end
    endtask

    task automatic apply(input int which, input vec_t v, input string name);
        vec_t g;
        @(negedge sys_clk);
        if (which == 0) begin
            ia.en = v.en; ia.period_end = v.pe;
        end else begin
            ib.en = v.en; ib.period_end = v.pe;
        end
        @(posedge sys_clk);
        #1;
        check(name, which, v);
        if (which == 0) ia.period_end = 1'b0;
        else            ib.period_end = 1'b0;
        if (v.pe) begin
            g      = v;
            g.vld  = 1'b0;
            g.done = 1'b0;
            @(posedge sys_clk);
            #1;
            check({name, "_gap"}, which, g);
        end
        repeat (2) @(posedge sys_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int bad;
        rst_n = 1'b0;
        ia.en = 1'b0; ia.period_end = 1'b0;
        ib.en = 1'b0; ib.period_end = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_a", 0, mk(0, 0, 0, 0, 0, 0));
        check("reset_b", 1, mk(0, 0, 0, 0, 0, 0));
        ia.en = 1'b1; ia.period_end = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_strobe_ignored", 0, mk(0, 0, 0, 0, 0, 0));
        @(negedge sys_clk);
        ia.en = 1'b0; ia.period_end = 1'b0;
        rst_n = 1'b1;

        // Full breath on the DUTY_MAX=100 / STEP=10 / 2 periods per step / hold 3 instance.
        add(0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            add(1, 1, (k - 1) * 10, 0, 1, 0);
            add(1, 1, k * 10, 1, (k == 10) ? 2 : 1, 0);
        end
        add(1, 1, 100, 0, 2, 0);
        add(1, 1, 100, 0, 2, 0);
        add(1, 1, 100, 0, 3, 0);
        for (int k = 1; k <= 10; k++) begin
            add(1, 1, 100 - (k - 1) * 10, 0, 3, 0);
            add(1, 1, 100 - k * 10, 1, (k == 10) ? 4 : 3, 0);
        end
        add(1, 1, 0, 0, 4, 0);
        add(1, 1, 0, 0, 4, 0);
        add(1, 1, 0, 0, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            add(1, 1, (k - 1) * 10, 0, 1, 0);
            add(1, 1, k * 10, 1, 1, 0);
        end
        add(0, 0, 40, 0, 1, 0);
        add(0, 0, 40, 0, 1, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0);
        foreach (tv[i]) apply(0, tv[i], $sformatf("breath_a[%0d]", i));

        // Strobe-free stretch must freeze everything, including the period count.
        apply(0, mk(1, 1, 0, 0, 1, 0), "nostrobe_start");
        apply(0, mk(1, 1, 0, 0, 1, 0), "nostrobe_cnt");
        apply(0, mk(1, 1, 10, 1, 1, 0), "nostrobe_step");
        @(negedge sys_clk);
        ia.en = 1'b1; ia.period_end = 1'b0;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge sys_clk);
            #1;
            if (ia.duty !== 16'd10 || ia.duty_valid !== 1'b0 || ia.phase !== 3'd1 || ia.cycle_done !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL nostrobe_static: %0d changed cycles, want 0", bad);
        end
        apply(0, mk(1, 1, 10, 0, 1, 0), "nostrobe_resume_cnt");
        apply(0, mk(1, 1, 20, 1, 1, 0), "nostrobe_resume_step");

        // Asynchronous reset mid-ramp, away from any clock edge.
        @(negedge sys_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", 0, mk(0, 0, 0, 0, 0, 0));
        ia.en = 1'b1; ia.period_end = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("async_reset_hold", 0, mk(0, 0, 0, 0, 0, 0));
        @(negedge sys_clk);
        ia.period_end = 1'b0;
        rst_n = 1'b1;
        apply(0, mk(1, 1, 0, 0, 1, 0), "restart_idle");
        apply(0, mk(1, 1, 0, 0, 1, 0), "restart_cnt");
        apply(0, mk(1, 1, 10, 1, 1, 0), "restart_step");
        @(negedge sys_clk);
        ia.en = 1'b0;

        // Saturating instance: DUTY_MAX=95, one period per step, no hold.
        tv.delete();
        add(1, 1, 0, 0, 1, 0);
        for (int k = 1; k <= 9; k++) add(1, 1, k * 10, 1, 1, 0);
        add(1, 1, 95, 1, 2, 0);
        add(1, 1, 95, 0, 3, 0);
        for (int k = 0; k <= 8; k++) add(1, 1, 85 - k * 10, 1, 3, 0);
        add(1, 1, 0, 1, 4, 0);
        add(1, 1, 0, 0, 1, 1);
        add(1, 1, 10, 1, 1, 0);
        foreach (tv[i]) apply(1, tv[i], $sformatf("sat_b[%0d]", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
